// File: rtl/uart_mmio.sv
//------------------------------------------------------------------------------
// uart_mmio
//
// Memory-mapped UART peripheral that sits between the core's data bus and an
// async_receiver / async_transmitter pair. Received bytes are queued in an RX
// FIFO, bytes written by the core are queued in a TX FIFO, and a small
// sequencer feeds the TX FIFO into the transmitter with a one-shot start pulse
// and a busy handshake.
//
// Register map (word index on addr_i):
//   0 DATA   : write pushes wdata_i[7:0] into TX FIFO; read pops RX FIFO
//   1 STATUS : {16'b0, rx_count[7:0], 3'b0, tx_idle, tx_overrun, rx_overrun,
//               tx_full, rx_not_empty}; writes ignored
//   2 CTRL   : bit0 rx_irq_en, bit1 loopback, bit2 write-1-to-clear overruns
//   3        : reserved, reads 0, writes ignored
//
// Ports:
//   clk_i            system clock (shared with core, RAM and UART)
//   rst_n_i          synchronous active-low reset
//   sel_i            bus access targets this block
//   addr_i[1:0]      word index
//   we_i, re_i       write / read strobes, qualified by sel_i
//   wdata_i[31:0]    write data
//   rdata_o[31:0]    registered read data, valid one cycle after sel_i & re_i
//   irq_o            registered rx_irq_en & rx_not_empty
//   rx_data_ready_i  one-cycle pulse from the receiver
//   rx_data_i[7:0]   received byte, valid with rx_data_ready_i
//   tx_busy_i        transmitter busy
//   tx_start_o       one-cycle start pulse to the transmitter
//   tx_data_o[7:0]   byte to send, held from tx_start_o until the next start
//
// Build option:
//   UART_MMIO_LOOPBACK_EN  when defined, CTRL bit 1 routes bytes leaving the
//                          TX FIFO straight back into the RX FIFO. When
//                          undefined, CTRL bit 1 reads 0 and the path is absent.
//------------------------------------------------------------------------------
module uart_mmio #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sel_i,
    input  logic [1:0]  addr_i,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    input  logic        rx_data_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o
);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } txState_e;

    // FIFO storage
    logic [7:0]       rxMem [FIFO_DEPTH];
    logic [7:0]       txMem [FIFO_DEPTH];

    // Registered state and next-state
    logic [PTR_W-1:0] rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
    logic [PTR_W-1:0] txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
    logic [CNT_W-1:0] rxCount_q, rxCount_d, txCount_q, txCount_d;
    logic             rxIrqEn_q, rxIrqEn_d;
    logic             rxOverrun_q, rxOverrun_d;
    logic             txOverrun_q, txOverrun_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             txStart_q, txStart_d;
    logic [7:0]       txData_q, txData_d;
    logic [1:0]       waitCnt_q, waitCnt_d;
    txState_e         state_q, state_d;

    // Bus decode
    logic             busRead, busWrite;
    logic             dataRead, dataWrite, ctrlWrite;

    // FIFO control
    logic             rxEmpty, rxFull, txEmpty, txFull;
    logic             rxPushReq, rxPush, rxPop, rxOverSet;
    logic             txPush, txPop, txOverSet;
    logic [7:0]       rxPushData, rxHead, txHead;
    logic             txDataLoad;
    logic             loopbackMode;
    logic             txIdle;
    logic [7:0]       rxCount8;
    logic [31:0]      statusWord, ctrlWord;

    assign busRead   = sel_i & re_i;
    assign busWrite  = sel_i & we_i;
    assign dataRead  = busRead  & (addr_i == ADDR_DATA);
    assign dataWrite = busWrite & (addr_i == ADDR_DATA);
    assign ctrlWrite = busWrite & (addr_i == ADDR_CTRL);

    assign rxEmpty = (rxCount_q == '0);
    assign rxFull  = (rxCount_q == DEPTH_CNT);
    assign txEmpty = (txCount_q == '0);
    assign txFull  = (txCount_q == DEPTH_CNT);
    assign rxHead  = rxMem[rxRdPtr_q];
    assign txHead  = txMem[txRdPtr_q];

    // The sequencer is the only consumer of the TX FIFO; it pops the head
    // during its single START cycle.
    assign txPop = (state_q == TX_START) & ~txEmpty;

`ifdef UART_MMIO_LOOPBACK_EN
    logic loopback_q, loopback_d;
    logic lbPush;
    logic unusedWdata;

    assign loopbackMode = loopback_q;

    // START without a tx_start pulse means the byte was claimed for loopback
    // when the sequencer left IDLE, so it goes into the RX FIFO instead.
    assign lbPush     = (state_q == TX_START) & ~txStart_q & ~txEmpty;
    assign rxPushReq  = lbPush | (rx_data_ready_i & ~loopback_q & ~lbPush);
    assign rxPushData = lbPush ? txHead : rx_data_i;
    assign loopback_d = ctrlWrite ? wdata_i[1] : loopback_q;
    assign unusedWdata = ^wdata_i[31:8];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            loopback_q <= 1'b0;
        end else begin
            loopback_q <= loopback_d;
        end
    end
`else
    logic unusedWdata;

    assign loopbackMode = 1'b0;
    assign rxPushReq    = rx_data_ready_i;
    assign rxPushData   = rx_data_i;
    assign unusedWdata  = ^{wdata_i[31:8], wdata_i[1]};
`endif

    // A full RX FIFO still accepts a byte when the same cycle pops one, so
    // only a push into a full FIFO with no pop counts as an overrun.
    assign rxPop     = dataRead & ~rxEmpty;
    assign rxPush    = rxPushReq & (~rxFull | rxPop);
    assign rxOverSet = rxPushReq & rxFull & ~rxPop;

    assign txPush    = dataWrite & ~txFull;
    assign txOverSet = dataWrite & txFull;

    assign txIdle   = txEmpty & (state_q == TX_IDLE);
    assign rxCount8 = 8'(rxCount_q);

    assign statusWord = {16'b0, rxCount8, 3'b0, txIdle, txOverrun_q,
                         rxOverrun_q, txFull, ~rxEmpty};
    assign ctrlWord   = {29'b0, 1'b0, loopbackMode, rxIrqEn_q};

    // FIFO pointer/count bookkeeping, control register and sticky overrun
    // flags. Pushes are gated above so the counts can neither overflow nor
    // underflow; an overrun set in the same cycle as a clear wins.
    always_comb begin
        rxWrPtr_d = rxWrPtr_q;
        rxRdPtr_d = rxRdPtr_q;
        rxCount_d = rxCount_q;
        txWrPtr_d = txWrPtr_q;
        txRdPtr_d = txRdPtr_q;
        txCount_d = txCount_q;

        if (rxPush) rxWrPtr_d = rxWrPtr_q + PTR_ONE;
        if (rxPop)  rxRdPtr_d = rxRdPtr_q + PTR_ONE;
        case ({rxPush, rxPop})
            2'b10:   rxCount_d = rxCount_q + CNT_ONE;
            2'b01:   rxCount_d = rxCount_q - CNT_ONE;
            default: rxCount_d = rxCount_q;
        endcase

        if (txPush) txWrPtr_d = txWrPtr_q + PTR_ONE;
        if (txPop)  txRdPtr_d = txRdPtr_q + PTR_ONE;
        case ({txPush, txPop})
            2'b10:   txCount_d = txCount_q + CNT_ONE;
            2'b01:   txCount_d = txCount_q - CNT_ONE;
            default: txCount_d = txCount_q;
        endcase

        rxIrqEn_d = ctrlWrite ? wdata_i[0] : rxIrqEn_q;

        if (rxOverSet)                   rxOverrun_d = 1'b1;
        else if (ctrlWrite & wdata_i[2]) rxOverrun_d = 1'b0;
        else                             rxOverrun_d = rxOverrun_q;

        if (txOverSet)                   txOverrun_d = 1'b1;
        else if (ctrlWrite & wdata_i[2]) txOverrun_d = 1'b0;
        else                             txOverrun_d = txOverrun_q;

        irq_d = rxIrqEn_q & ~rxEmpty;
    end

    // Read mux. Every register is sampled before this cycle's writes land,
    // so a read and write to the same address returns the old value. A DATA
    // read of an empty FIFO returns 0 even if a byte arrives in that cycle.
    always_comb begin
        rdata_d = rdata_q;
        if (busRead) begin
            case (addr_i)
                ADDR_DATA:   rdata_d = rxPop ? {24'b0, rxHead} : 32'b0;
                ADDR_STATUS: rdata_d = statusWord;
                ADDR_CTRL:   rdata_d = ctrlWord;
                default:     rdata_d = 32'b0;
            endcase
        end
    end

    // TX sequencer next-state. tx_start and tx_data are registered on the
    // IDLE->START edge so both are stable for the whole START cycle. The
    // WAIT_BUSY timeout keeps a transmitter that never raises busy from
    // stalling the queue.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = 2'd0;
        txStart_d  = 1'b0;
        txDataLoad = 1'b0;

        case (state_q)
            TX_IDLE: begin
                if (~txEmpty & ~tx_busy_i) begin
                    state_d    = TX_START;
                    txStart_d  = ~loopbackMode;
                    txDataLoad = ~loopbackMode;
                end
            end
            TX_START: begin
                state_d = txStart_q ? TX_WAIT_BUSY : TX_IDLE;
            end
            TX_WAIT_BUSY: begin
                if (tx_busy_i || (waitCnt_q == 2'd3)) begin
                    state_d = TX_WAIT_DONE;
                end else begin
                    waitCnt_d = waitCnt_q + 2'd1;
                end
            end
            TX_WAIT_DONE: begin
                if (~tx_busy_i) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        txData_d = txDataLoad ? txHead : txData_q;
    end

    // FIFO storage needs no reset: entries are only read once the counts
    // say they were written.
    always_ff @(posedge clk_i) begin
        if (rxPush) rxMem[rxWrPtr_q] <= rxPushData;
        if (txPush) txMem[txWrPtr_q] <= wdata_i[7:0];
    end

    // State registers. Reset empties both FIFOs, clears CTRL and the flags
    // and abandons any byte in flight with tx_start low.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rxWrPtr_q   <= '0;
            rxRdPtr_q   <= '0;
            rxCount_q   <= '0;
            txWrPtr_q   <= '0;
            txRdPtr_q   <= '0;
            txCount_q   <= '0;
            rxIrqEn_q   <= 1'b0;
            rxOverrun_q <= 1'b0;
            txOverrun_q <= 1'b0;
            rdata_q     <= 32'b0;
            irq_q       <= 1'b0;
            txStart_q   <= 1'b0;
            txData_q    <= 8'b0;
            waitCnt_q   <= 2'd0;
            state_q     <= TX_IDLE;
        end else begin
            rxWrPtr_q   <= rxWrPtr_d;
            rxRdPtr_q   <= rxRdPtr_d;
            rxCount_q   <= rxCount_d;
            txWrPtr_q   <= txWrPtr_d;
            txRdPtr_q   <= txRdPtr_d;
            txCount_q   <= txCount_d;
            rxIrqEn_q   <= rxIrqEn_d;
            rxOverrun_q <= rxOverrun_d;
            txOverrun_q <= txOverrun_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
            txStart_q   <= txStart_d;
            txData_q    <= txData_d;
            waitCnt_q   <= waitCnt_d;
            state_q     <= state_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign irq_o      = irq_q;
    assign tx_start_o = txStart_q;
    assign tx_data_o  = txData_q;

endmodule

// File: tb/tb_uart_mmio.sv
//------------------------------------------------------------------------------
// tb_uart_mmio
//
// Self-checking bench for uart_mmio. Bus/RX behaviour is driven from a table
// of per-cycle vectors with hand-computed expected read data and irq; the TX
// sequencer, overrun, timeout and reset-mid-byte cases are hand-written
// sequences. A transmitter model holds tx_busy for 10 cycles after each start
// pulse and records every pulse.
//------------------------------------------------------------------------------
module tb_uart_mmio;

    localparam int DEPTH       = 16;
    localparam int BUSY_CYCLES = 10;
    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;

    logic        clock = 1'b0;
    logic        rstN = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;
    logic        rxReady = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        txBusy = 1'b0;
    logic        txStart;
    logic [7:0]  txData;

    int checks = 0;
    int errors = 0;

    // Transmitter model state
    int         cycle = 0;
    int         lastPulse = -1;
    int         busyLeft = 0;
    int         pulseCount = 0;
    logic       busyEn = 1'b1;
    logic       busyHold = 1'b0;
    logic [7:0] pulseData[$];
    int         pulseCycle[$];

    always #5 clock = ~clock;

    uart_mmio #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i           (clock),
        .rst_n_i         (rstN),
        .sel_i           (sel),
        .addr_i          (addr),
        .we_i            (we),
        .re_i            (re),
        .wdata_i         (wdata),
        .rdata_o         (rdata),
        .irq_o           (irq),
        .rx_data_ready_i (rxReady),
        .rx_data_i       (rxData),
        .tx_busy_i       (txBusy),
        .tx_start_o      (txStart),
        .tx_data_o       (txData)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic        rxReady;
        logic [7:0]  rxData;
        logic        chkRdata;
        logic [31:0] expRdata;
        logic        chkIrq;
        logic        expIrq;
    } vector_t;

    vector_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Transmitter model and tx_start monitor, sampled on the falling edge
    always @(negedge clock) begin
        cycle++;
        if (txStart === 1'b1) begin
            if (lastPulse >= 0)
                checkOutput("tx_start spacing>=4", 32'(cycle - lastPulse >= 4), 32'd1);
            pulseData.push_back(txData);
            pulseCycle.push_back(cycle);
            lastPulse = cycle;
            pulseCount++;
            busyLeft = busyEn ? BUSY_CYCLES : 0;
        end else if (busyLeft > 0) begin
            busyLeft--;
        end
        txBusy = busyHold | (busyLeft > 0);
    end

    function automatic vector_t idleVec();
        vector_t v;
        v.sel = 1'b0; v.addr = 2'd0; v.we = 1'b0; v.re = 1'b0; v.wdata = 32'd0;
        v.rxReady = 1'b0; v.rxData = 8'd0;
        v.chkRdata = 1'b0; v.expRdata = 32'd0;
        v.chkIrq = 1'b1; v.expIrq = 1'b0;
        return v;
    endfunction

    function automatic vector_t rdVec(input logic [1:0] a, input logic [31:0] e);
        vector_t v = idleVec();
        v.sel = 1'b1; v.re = 1'b1; v.addr = a; v.chkRdata = 1'b1; v.expRdata = e;
        return v;
    endfunction

    function automatic vector_t wrVec(input logic [1:0] a, input logic [31:0] d);
        vector_t v = idleVec();
        v.sel = 1'b1; v.we = 1'b1; v.addr = a; v.wdata = d;
        return v;
    endfunction

    function automatic vector_t rxVec(input logic [7:0] b);
        vector_t v = idleVec();
        v.rxReady = 1'b1; v.rxData = b;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vector_t v);
        sel = v.sel; addr = v.addr; we = v.we; re = v.re; wdata = v.wdata;
        rxReady = v.rxReady; rxData = v.rxData;
        tick();
        sel = 1'b0; we = 1'b0; re = 1'b0; rxReady = 1'b0;
    endtask

    task automatic readCheck(input logic [1:0] a, input logic [31:0] e, input string name);
        applyStimulus(rdVec(a, e));
        checkOutput(name, rdata, e);
    endtask

    task automatic waitPulses(input int target, input int maxCycles);
        int n = 0;
        while (pulseCount < target && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput("tx_start pulse count", 32'(pulseCount), 32'(target));
    endtask

    task automatic waitTxIdle(input int maxCycles);
        int n = 0;
        do begin
            applyStimulus(rdVec(A_STATUS, 32'd0));
            n++;
        end while (rdata[4] !== 1'b1 && n < maxCycles);
        checkOutput("tx_idle reached", 32'(rdata[4]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vector_t v;
        int base;

        // ---------------- vector table ----------------
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));
        vecs.push_back(rdVec(A_CTRL,   32'h0));
        vecs.push_back(rdVec(A_RSVD,   32'h0));
        vecs.push_back(wrVec(A_RSVD,   32'hFFFF_FFFF));
        vecs.push_back(rdVec(A_RSVD,   32'h0));
        vecs.push_back(wrVec(A_STATUS, 32'hFFFF_FFFF));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));
        // 17 bytes into a 16-deep FIFO: last one overruns
        for (int i = 0; i <= 16; i++) vecs.push_back(rxVec(8'(i)));
        v = idleVec(); v.chkRdata = 1'b1; v.expRdata = 32'h10; vecs.push_back(v);
        vecs.push_back(rdVec(A_STATUS, 32'h0000_1015));
        for (int i = 0; i < 16; i++) vecs.push_back(rdVec(A_DATA, 32'(i)));
        vecs.push_back(rdVec(A_DATA,   32'h0));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0014));
        vecs.push_back(wrVec(A_CTRL,   32'h4));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));
        vecs.push_back(rdVec(A_CTRL,   32'h0));
        // irq: enable, one byte, read it back
        vecs.push_back(wrVec(A_CTRL, 32'h1));
        vecs.push_back(rdVec(A_CTRL, 32'h1));
        vecs.push_back(rxVec(8'h5A));
        v = idleVec(); v.expIrq = 1'b1; vecs.push_back(v);
        v = rdVec(A_DATA, 32'h5A); v.expIrq = 1'b1; vecs.push_back(v);
        vecs.push_back(idleVec());
        // read and write CTRL together returns the old value
        v = rdVec(A_CTRL, 32'h1); v.we = 1'b1; v.wdata = 32'h0; vecs.push_back(v);
        vecs.push_back(rdVec(A_CTRL, 32'h0));
        // empty FIFO, push and DATA read in the same cycle
        v = rdVec(A_DATA, 32'h0); v.rxReady = 1'b1; v.rxData = 8'h33; vecs.push_back(v);
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0111));
        vecs.push_back(rdVec(A_DATA,   32'h33));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));
        // full FIFO, pop and push in the same cycle
        for (int i = 0; i < 16; i++) vecs.push_back(rxVec(8'(8'h60 + i)));
        v = rdVec(A_DATA, 32'h60); v.rxReady = 1'b1; v.rxData = 8'h77; vecs.push_back(v);
        vecs.push_back(rdVec(A_STATUS, 32'h0000_1011));
        for (int i = 1; i < 16; i++) vecs.push_back(rdVec(A_DATA, 32'(8'h60 + i)));
        vecs.push_back(rdVec(A_DATA,   32'h77));
        vecs.push_back(rdVec(A_DATA,   32'h0));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));
        // overrun set and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) vecs.push_back(rxVec(8'(8'h80 + i)));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_1011));
        v = wrVec(A_CTRL, 32'h4); v.rxReady = 1'b1; v.rxData = 8'hEE; vecs.push_back(v);
        vecs.push_back(rdVec(A_STATUS, 32'h0000_1015));
        vecs.push_back(wrVec(A_CTRL, 32'h4));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_1011));
        for (int i = 0; i < 16; i++) vecs.push_back(rdVec(A_DATA, 32'(8'h80 + i)));
        vecs.push_back(rdVec(A_STATUS, 32'h0000_0010));

        // ---------------- reset ----------------
        $display("[TB] reset");
        rstN = 1'b0;
        repeat (3) tick();
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset tx_start", 32'(txStart), 32'h0);
        checkOutput("reset tx_data", 32'(txData), 32'h0);
        rstN = 1'b1;
        tick();

        // ---------------- table ----------------
        $display("[TB] applying %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chkRdata)
                checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
            if (vecs[i].chkIrq)
                checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].expIrq));
        end
        checkOutput("no tx_start during rx tests", 32'(pulseCount), 32'd0);

        // ---------------- TX: two bytes with busy model ----------------
        $display("[TB] tx two bytes");
        base = pulseCount;
        applyStimulus(wrVec(A_DATA, 32'h41));
        checkOutput("tx_start low after write", 32'(txStart), 32'h0);
        applyStimulus(wrVec(A_DATA, 32'h42));
        checkOutput("tx_start 2 cycles after write", 32'(txStart), 32'h1);
        checkOutput("tx_data with start", 32'(txData), 32'h41);
        applyStimulus(idleVec());
        checkOutput("tx_start one cycle", 32'(txStart), 32'h0);
        waitPulses(base + 2, 60);
        if (pulseCount >= base + 2) begin
            checkOutput("tx byte 0", 32'(pulseData[base]), 32'h41);
            checkOutput("tx byte 1", 32'(pulseData[base + 1]), 32'h42);
        end
        readCheck(A_STATUS, 32'h0, "status while sending");
        waitTxIdle(40);
        readCheck(A_STATUS, 32'h10, "status after send");

        // ---------------- TX FIFO full / overrun ----------------
        $display("[TB] tx overrun");
        base = pulseCount;
        busyHold = 1'b1;
        repeat (2) tick();
        for (int i = 0; i <= 16; i++) applyStimulus(wrVec(A_DATA, 32'(8'hA0 + i)));
        readCheck(A_STATUS, 32'h0000_000A, "status tx full+overrun");
        checkOutput("no start while busy", 32'(pulseCount), 32'(base));
        busyHold = 1'b0;
        waitPulses(base + 16, 16 * 20);
        if (pulseCount >= base + 16)
            for (int i = 0; i < 16; i++)
                checkOutput($sformatf("tx fifo byte %0d", i), 32'(pulseData[base + i]), 32'(8'hA0 + i));
        waitTxIdle(40);
        readCheck(A_STATUS, 32'h18, "status tx overrun sticky");
        applyStimulus(wrVec(A_CTRL, 32'h4));
        readCheck(A_STATUS, 32'h10, "status tx overrun cleared");

        // ---------------- TX timeout: transmitter never busy ----------------
        $display("[TB] tx timeout");
        busyEn = 1'b0;
        base = pulseCount;
        applyStimulus(wrVec(A_DATA, 32'h55));
        applyStimulus(wrVec(A_DATA, 32'h56));
        waitPulses(base + 2, 40);
        if (pulseCount >= base + 2) begin
            checkOutput("timeout gap in 4..8",
                32'((pulseCycle[base + 1] - pulseCycle[base]) >= 4 &&
                    (pulseCycle[base + 1] - pulseCycle[base]) <= 8), 32'd1);
            checkOutput("timeout byte 1", 32'(pulseData[base + 1]), 32'h56);
        end
        waitTxIdle(20);
        busyEn = 1'b1;

        // ---------------- reset mid-byte ----------------
        $display("[TB] reset mid-byte");
        base = pulseCount;
        applyStimulus(wrVec(A_DATA, 32'h61));
        applyStimulus(wrVec(A_DATA, 32'h62));
        waitPulses(base + 1, 10);
        repeat (3) tick();
        rstN = 1'b0;
        repeat (2) begin
            tick();
            checkOutput("tx_start in reset", 32'(txStart), 32'h0);
        end
        checkOutput("tx_data after reset", 32'(txData), 32'h0);
        rstN = 1'b1;
        base = pulseCount;
        repeat (30) tick();
        checkOutput("no pulse after reset", 32'(pulseCount), 32'(base));
        readCheck(A_STATUS, 32'h10, "status after mid reset");

        // ---------------- loopback ----------------
`ifdef UART_MMIO_LOOPBACK_EN
        $display("[TB] loopback");
        base = pulseCount;
        applyStimulus(wrVec(A_CTRL, 32'h2));
        readCheck(A_CTRL, 32'h2, "ctrl loopback");
        applyStimulus(wrVec(A_DATA, 32'hC3));
        repeat (10) tick();
        checkOutput("no tx_start in loopback", 32'(pulseCount), 32'(base));
        readCheck(A_STATUS, 32'h111, "status loopback");
        readCheck(A_DATA, 32'hC3, "loopback data");
        applyStimulus(wrVec(A_CTRL, 32'h0));
`else
        $display("[TB] loopback absent");
        applyStimulus(wrVec(A_CTRL, 32'h3));
        readCheck(A_CTRL, 32'h1, "ctrl bit1 unimplemented");
        applyStimulus(wrVec(A_CTRL, 32'h0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
